// File: rtl/dfr_pkg.sv
// Shared definitions for the DFR batch controller: state encoding and
// helpers that pick the phase following init/run.
package dfr_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_INIT_STEP,
    ST_INIT_WAIT,
    ST_RUN_STEP,
    ST_RUN_WAIT,
    ST_MM_START,
    ST_MM_WAIT,
    ST_DONE
  } dfr_state_e;

  localparam dfr_state_e PHASE_AFTER_RUN_MM   = ST_MM_START;
  localparam dfr_state_e PHASE_AFTER_RUN_SKIP = ST_DONE;

  function automatic dfr_state_e phase_after_run(input logic skip_mm);
    return skip_mm ? PHASE_AFTER_RUN_SKIP : PHASE_AFTER_RUN_MM;
  endfunction

  // An empty run phase falls straight through to the multiply (or done).
  function automatic dfr_state_e phase_after_init(input logic run_empty, input logic skip_mm);
    return run_empty ? phase_after_run(skip_mm) : ST_RUN_STEP;
  endfunction

endpackage

// File: rtl/dfr_wait_timer.sv
// Handshake wait timer: counts non-completing wait cycles and flags expiry
// in the cycle that reaches the limit (limit of zero disables expiry).
module dfr_wait_timer #(
  parameter int unsigned TO_WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic [TO_WIDTH-1:0] i_limit,
  output logic                o_expired
);

  localparam logic [TO_WIDTH-1:0] ONE = TO_WIDTH'(1);

  logic [TO_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  // r_cnt holds the cycles already elapsed, so this cycle is number r_cnt+1.
  assign o_expired = i_en && (i_limit != '0) && (r_cnt == (i_limit - ONE));

endmodule

// File: rtl/dfr_batch_controller.sv
// Sequences one DFR batch: reset, warm-up samples, captured samples, optional
// matrix multiply, with abort and per-handshake timeout. All outputs registered.
module dfr_batch_controller
  import dfr_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned TO_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] init_len,
  input  logic [CNT_WIDTH-1:0] run_len,
  input  logic                 skip_mm,
  input  logic [TO_WIDTH-1:0]  timeout_limit,
  input  logic                 reservoir_valid,
  input  logic                 matrix_multiply_busy,
  output logic                 busy,
  output logic                 reservoir_rst,
  output logic                 matrix_multiply_rst,
  output logic                 reservoir_en,
  output logic                 reservoir_history_en,
  output logic                 matrix_multiply_start,
  output logic [CNT_WIDTH-1:0] sample_idx,
  output logic                 dfr_done,
  output logic                 timeout_err,
  output logic                 aborted
);

  dfr_state_e           r_state, w_state_next;
  logic [CNT_WIDTH-1:0] r_init_len, r_run_len, r_idx, w_idx_next, w_idx_inc;
  logic                 r_skip_mm;
  logic [TO_WIDTH-1:0]  r_limit;
  logic                 r_timeout_err, r_aborted, r_mm_first;
  logic                 w_accept, w_abort_set, w_timeout_set;
  logic                 w_in_wait, w_wait_done, w_expired;
  logic                 r_busy, r_res_rst, r_mm_rst, r_res_en, r_hist_en, r_mm_start, r_done;
  logic                 w_busy, w_res_rst, w_mm_rst, w_res_en, w_hist_en, w_mm_start, w_done;

  assign w_idx_inc = r_idx + CNT_WIDTH'(1);
  assign w_in_wait = (r_state == ST_INIT_WAIT) || (r_state == ST_RUN_WAIT) || (r_state == ST_MM_WAIT);
  // Multiplier busy is not yet meaningful in the first MM_WAIT cycle.
  assign w_wait_done = (((r_state == ST_INIT_WAIT) || (r_state == ST_RUN_WAIT)) && reservoir_valid) ||
                       ((r_state == ST_MM_WAIT) && !r_mm_first && !matrix_multiply_busy);

  dfr_wait_timer #(.TO_WIDTH(TO_WIDTH)) u_wait_timer (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (!w_in_wait),
    .i_en     (w_in_wait && !w_wait_done),
    .i_limit  (r_limit),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_init_len    <= '0;
      r_run_len     <= '0;
      r_skip_mm     <= 1'b0;
      r_limit       <= '0;
      r_timeout_err <= 1'b0;
      r_aborted     <= 1'b0;
      r_mm_first    <= 1'b0;
      r_busy        <= 1'b0;
      r_res_rst     <= 1'b0;
      r_mm_rst      <= 1'b0;
      r_res_en      <= 1'b0;
      r_hist_en     <= 1'b0;
      r_mm_start    <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_mm_first <= (r_state == ST_MM_START);
      r_busy     <= w_busy;
      r_res_rst  <= w_res_rst;
      r_mm_rst   <= w_mm_rst;
      r_res_en   <= w_res_en;
      r_hist_en  <= w_hist_en;
      r_mm_start <= w_mm_start;
      r_done     <= w_done;
      if (w_accept) begin
        r_init_len    <= init_len;
        r_run_len     <= run_len;
        r_skip_mm     <= skip_mm;
        r_limit       <= timeout_limit;
        r_timeout_err <= 1'b0;
        r_aborted     <= 1'b0;
      end else begin
        if (w_abort_set)   r_aborted     <= 1'b1;
        if (w_timeout_set) r_timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_accept      = 1'b0;
    w_abort_set   = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_idx_next   = '0;
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_idx_next   = '0;
        w_state_next = (r_init_len != '0) ? ST_INIT_STEP
                                          : phase_after_init(r_run_len == '0, r_skip_mm);
      end
      ST_INIT_STEP: w_state_next = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (w_wait_done) begin
          if (w_idx_inc == r_init_len) begin
            w_idx_next   = '0;
            w_state_next = phase_after_init(r_run_len == '0, r_skip_mm);
          end else begin
            w_idx_next   = w_idx_inc;
            w_state_next = ST_INIT_STEP;
          end
        end
      end
      ST_RUN_STEP: w_state_next = ST_RUN_WAIT;
      ST_RUN_WAIT: begin
        if (w_wait_done) begin
          w_idx_next   = w_idx_inc;
          w_state_next = (w_idx_inc == r_run_len) ? phase_after_run(r_skip_mm) : ST_RUN_STEP;
        end
      end
      ST_MM_START: w_state_next = ST_MM_WAIT;
      ST_MM_WAIT:  if (w_wait_done) w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && abort) begin
      w_abort_set  = 1'b1;
      w_idx_next   = r_idx;
      w_state_next = ST_IDLE;
    end else if (w_expired) begin
      w_timeout_set = 1'b1;
      w_idx_next    = r_idx;
      w_state_next  = ST_IDLE;
    end
  end

  // Outputs are decoded from the next state and registered, so each pulse
  // lines up with the cycle the controller spends in that state.
  always_comb begin
    w_busy     = (w_state_next != ST_IDLE);
    w_res_rst  = (w_state_next == ST_CLEAR);
    w_mm_rst   = (w_state_next == ST_CLEAR);
    w_res_en   = (w_state_next == ST_INIT_STEP) || (w_state_next == ST_RUN_STEP);
    w_hist_en  = (w_state_next == ST_RUN_STEP);
    w_mm_start = (w_state_next == ST_MM_START);
    w_done     = (w_state_next == ST_DONE);
  end

  assign busy                  = r_busy;
  assign reservoir_rst         = r_res_rst;
  assign matrix_multiply_rst   = r_mm_rst;
  assign reservoir_en          = r_res_en;
  assign reservoir_history_en  = r_hist_en;
  assign matrix_multiply_start = r_mm_start;
  assign sample_idx            = r_idx;
  assign dfr_done              = r_done;
  assign timeout_err           = r_timeout_err;
  assign aborted               = r_aborted;

endmodule

// File: tb/tb_dfr_batch_controller.sv
// Scoreboard bench for dfr_batch_controller: per-batch expectations from a
// behavioural model, checked by a monitor when the controller drops busy.
module tb_dfr_batch_controller;

  localparam int unsigned CW = 4;
  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] init_len = '0;
  logic [CW-1:0] run_len = '0;
  logic          skip_mm = 1'b0;
  logic [TW-1:0] timeout_limit = '0;
  logic          reservoir_valid = 1'b0;
  logic          mm_busy = 1'b0;
  logic          o_busy, o_res_rst, o_mm_rst, o_res_en, o_hist_en, o_mm_start, o_done;
  logic          o_timeout_err, o_aborted;
  logic [CW-1:0] o_idx;

  always #5 clk = ~clk;

  dfr_batch_controller #(.CNT_WIDTH(CW), .TO_WIDTH(TW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .abort                (abort),
    .init_len             (init_len),
    .run_len              (run_len),
    .skip_mm              (skip_mm),
    .timeout_limit        (timeout_limit),
    .reservoir_valid      (reservoir_valid),
    .matrix_multiply_busy (mm_busy),
    .busy                 (o_busy),
    .reservoir_rst        (o_res_rst),
    .matrix_multiply_rst  (o_mm_rst),
    .reservoir_en         (o_res_en),
    .reservoir_history_en (o_hist_en),
    .matrix_multiply_start(o_mm_start),
    .sample_idx           (o_idx),
    .dfr_done             (o_done),
    .timeout_err          (o_timeout_err),
    .aborted              (o_aborted)
  );

  typedef struct {
    int en; int hist; int mm; int done; int rr; int mr;
    int terr; int abt; int idx; int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_batches = 0;
  int   cfg_k = 1;
  int   cfg_b = 0;
  int   cfg_abort_at = 0;
  bit   resp_active = 1'b0;
  bit   mm_active = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Outcome of one batch from the handshake rules: every sample answers in
  // wait cycle k, the multiplier stays busy for b cycles after its start.
  function automatic exp_t model(input int init, input int run, input int skip, input int limit,
                                 input int k, input int b, input int abort_at);
    exp_t e;
    bit   ok;
    int   c;
    e = '{default: 0};
    e.rr = 1;
    e.mr = 1;
    ok = (limit == 0) || (k <= limit);
    c = (b + 1 > 2) ? b + 1 : 2;
    if (init > 0 && !ok) begin
      e.en = 1; e.terr = 1;
    end else if (run > 0 && !ok) begin
      e.en = init + 1; e.hist = 1; e.terr = 1;
    end else if (abort_at > 0) begin
      e.en = init + abort_at; e.hist = abort_at; e.idx = abort_at - 1; e.abt = 1;
    end else begin
      e.en = init + run; e.hist = run; e.idx = run;
      if (skip == 0) begin
        e.mm = 1;
        if (limit != 0 && c > limit) e.terr = 1;
      end
      if (e.terr == 0) begin
        e.done = 1;
        e.lat = 1 + (init + run) * (1 + k) + ((skip != 0) ? 0 : 1 + c);
      end
    end
    return e;
  endfunction

  // Reservoir responder: optional stray valid in STEP, real valid in wait
  // cycle k (or abort instead of it), optional stray valid in the next cycle.
  initial begin
    int hist_seen = 0;
    forever begin
      @(posedge clk); #1;
      reservoir_valid = 1'b0;
      if (o_res_rst) hist_seen = 0;
      while (o_res_en) begin
        resp_active = 1'b1;
        if (o_hist_en) hist_seen++;
        reservoir_valid = 1'($urandom_range(0, 1));
        for (int j = 1; j <= cfg_k; j++) begin
          @(posedge clk); #1;
          reservoir_valid = 1'b0;
          if (j == cfg_k) begin
            if (cfg_abort_at != 0 && hist_seen == cfg_abort_at) abort = 1'b1;
            else reservoir_valid = 1'b1;
          end
        end
        @(posedge clk); #1;
        abort = 1'b0;
        reservoir_valid = 1'($urandom_range(0, 1));
      end
      resp_active = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (o_mm_start) begin
        mm_active = 1'b1;
        if (cfg_b > 0) begin
          mm_busy = 1'b1;
          repeat (cfg_b + 1) @(posedge clk);
          #1;
          mm_busy = 1'b0;
        end
        mm_active = 1'b0;
      end
    end
  end

  int  m_edge = 0, m_start = 0, m_done_edge = 0;
  int  m_en = 0, m_hist = 0, m_mm = 0, m_done = 0, m_rr = 0, m_mr = 0;
  bit  m_prev_busy = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      m_edge++;
      if (o_busy && !m_prev_busy) begin
        m_start = m_edge;
        m_en = 0; m_hist = 0; m_mm = 0; m_done = 0; m_rr = 0; m_mr = 0;
      end
      if (o_res_en)   m_en++;
      if (o_hist_en)  m_hist++;
      if (o_mm_start) m_mm++;
      if (o_res_rst)  m_rr++;
      if (o_mm_rst)   m_mr++;
      if (o_done) begin
        m_done++;
        m_done_edge = m_edge;
      end
      if (!o_busy && m_prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_batch", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("reservoir_en_count", m_en, e.en);
          check("history_en_count", m_hist, e.hist);
          check("mm_start_count", m_mm, e.mm);
          check("dfr_done_count", m_done, e.done);
          check("reservoir_rst_count", m_rr, e.rr);
          check("mm_rst_count", m_mr, e.mr);
          check("timeout_err", int'(o_timeout_err), e.terr);
          check("aborted", int'(o_aborted), e.abt);
          check("sample_idx", int'(o_idx), e.idx);
          if (e.done != 0) check("done_latency", m_done_edge - m_start, e.lat);
        end
        n_batches++;
      end
      m_prev_busy = o_busy;
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_pulses"}, int'({o_busy, o_res_rst, o_mm_rst, o_res_en, o_hist_en, o_mm_start, o_done}), 0);
    check({name, "_status"}, int'({o_timeout_err, o_aborted}), 0);
    check({name, "_idx"}, int'(o_idx), 0);
  endtask

  task automatic wait_batch(input int target);
    int waited = 0;
    while (n_batches < target && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
      start = (waited == 2 && o_busy) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    if (n_batches < target) begin
      check("batch_completion_timeout", n_batches, target);
      exp_q.delete();
      reset_dut();
    end
    waited = 0;
    while ((resp_active || mm_active) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic launch(input int init, input int run, input int skip, input int limit,
                        input int k, input int b, input int abort_at);
    cfg_k = k; cfg_b = b; cfg_abort_at = abort_at;
    init_len = CW'(init); run_len = CW'(run); skip_mm = 1'(skip); timeout_limit = TW'(limit);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble config after acceptance: the controller must use its latched copy.
    init_len = CW'($urandom); run_len = CW'($urandom);
    skip_mm = 1'($urandom); timeout_limit = TW'($urandom);
  endtask

  task automatic run_batch(input int init, input int run, input int skip, input int limit,
                           input int k, input int b, input int abort_at);
    int target = n_batches + 1;
    exp_q.push_back(model(init, run, skip, limit, k, b, abort_at));
    launch(init, run, skip, limit, k, b, abort_at);
    wait_batch(target);
  endtask

  task automatic reset_in_mm_wait();
    int   target = n_batches + 1;
    int   waited = 0;
    exp_t e = '{default: 0};
    e.en = 2; e.hist = 1; e.mm = 1; e.rr = 1; e.mr = 1;
    exp_q.push_back(e);
    launch(1, 1, 0, 0, 1, 20, 0);
    while (!o_mm_start && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("mm_start_seen_before_reset", int'(o_mm_start), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs_zero("reset_in_mm_wait");
    wait_batch(target);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_dut();
    check_outputs_zero("reset_state");
    repeat (2) @(posedge clk);
    #1;

    run_batch(3, 4, 0, 0, 2, 3, 0);    // nominal batch with multiply
    run_batch(0, 0, 1, 0, 1, 0, 0);    // empty batch straight to done
    run_batch(3, 2, 0, 5, 7, 0, 0);    // reservoir never answers in time
    run_batch(1, 6, 0, 0, 1, 2, 2);    // abort while waiting for run sample 2
    run_batch(1, 6, 0, 0, 1, 2, 0);    // rerun clears aborted
    reset_in_mm_wait();
    run_batch(2, 3, 0, 0, 1, 0, 0);    // start accepted after reset
    run_batch(15, 15, 1, 0, 1, 0, 0);  // maximum lengths
    run_batch(2, 0, 0, 0, 1, 0, 0);    // empty run phase
    run_batch(0, 2, 1, 3, 3, 0, 0);    // answer exactly at the limit
    run_batch(0, 3, 0, 3, 1, 5, 0);    // multiplier exceeds the limit
    run_batch(1, 2, 0, 3, 1, 2, 0);    // multiplier finishes at the limit

    for (int n = 0; n < 30; n++) begin
      int init, run, skip, limit, k, b, ab;
      init  = $urandom_range(0, 5);
      run   = $urandom_range(0, 6);
      skip  = $urandom_range(0, 1);
      limit = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      k     = $urandom_range(1, 4);
      b     = $urandom_range(0, 5);
      ab    = (run > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, run) : 0;
      run_batch(init, run, skip, limit, k, b, ab);
    end

    if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dfr_batch_controller.md
DFR_BATCH_CONTROLLER -- requirements
Module: dfr_batch_controller

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of all sample counters and length inputs.
REQ-002 Parameter TO_WIDTH, default 16, width of timeout counter and limit.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begin batch; sampled only in IDLE.
REQ-006 abort  in  1  terminate active batch.
REQ-007 init_len  in  CNT_WIDTH  warm-up samples (no history capture); latched at accepted start.
REQ-008 run_len  in  CNT_WIDTH  captured samples; latched at accepted start.
REQ-009 skip_mm  in  1  omit matrix-multiply phase; latched at accepted start.
REQ-010 timeout_limit  in  TO_WIDTH  max wait cycles per handshake; 0 disables; latched at accepted start.
REQ-011 reservoir_valid  in  1  reservoir finished current sample.
REQ-012 matrix_multiply_busy  in  1  multiplier running.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 reservoir_rst, matrix_multiply_rst  out  1 each  one-cycle reset pulses.
REQ-015 reservoir_en  out  1  one-cycle pulse per sample step.
REQ-016 reservoir_history_en  out  1  one-cycle pulse, coincident with reservoir_en in run phase only.
REQ-017 matrix_multiply_start  out  1  one-cycle pulse.
REQ-018 sample_idx  out  CNT_WIDTH  samples completed in current phase.
REQ-019 dfr_done  out  1  one-cycle pulse at normal completion.
REQ-020 timeout_err, aborted  out  1 each  sticky status, cleared by next accepted start or rst.

Function
REQ-021 All outputs SHALL be registered; state encoding: IDLE, CLEAR, INIT_STEP, INIT_WAIT, RUN_STEP, RUN_WAIT, MM_START, MM_WAIT, DONE.
REQ-022 IDLE: start=1 -> latch config, clear status, go CLEAR; else hold.
REQ-023 CLEAR (1 cycle): reservoir_rst=1, matrix_multiply_rst=1, sample_idx=0; next INIT_STEP if init_len!=0, else RUN_STEP if run_len!=0, else MM_START (or DONE if skip_mm).
REQ-024 INIT_STEP (1 cycle): reservoir_en=1; next INIT_WAIT.
REQ-025 INIT_WAIT: reservoir_valid=1 -> sample_idx+1; if new count==init_len, sample_idx=0 and next RUN_STEP (MM_START/DONE per REQ-023 if run_len==0); else INIT_STEP.
REQ-026 RUN_STEP (1 cycle): reservoir_en=1, reservoir_history_en=1; next RUN_WAIT.
REQ-027 RUN_WAIT: reservoir_valid=1 -> sample_idx+1; if new count==run_len next MM_START (DONE if skip_mm); else RUN_STEP.
REQ-028 MM_START (1 cycle): matrix_multiply_start=1; next MM_WAIT.
REQ-029 MM_WAIT: matrix_multiply_busy ignored in first cycle; thereafter busy=0 -> DONE.
REQ-030 DONE (1 cycle): dfr_done=1; next IDLE; sample_idx holds final run count.
REQ-031 Timeout counter clears on entry to each WAIT state, increments each WAIT cycle without completion; reaching timeout_limit (limit!=0) -> timeout_err=1, go IDLE, no dfr_done.
REQ-032 abort=1 in any non-IDLE state -> aborted=1, next IDLE, no pulses issued that cycle; abort in IDLE ignored.
REQ-033 Priority: rst > abort > timeout > normal transition.
REQ-034 reservoir_valid outside INIT_WAIT/RUN_WAIT SHALL be ignored; start outside IDLE ignored.
REQ-035 Counters SHALL not wrap: max length 2^CNT_WIDTH-1 completes exactly at that count.
REQ-036 Sample step throughput: minimum 2 cycles/sample (STEP + one-cycle WAIT).

Reset
REQ-037 rst=1 at a clock edge -> state IDLE, all outputs 0, sample_idx=0, status cleared, latched config 0; applies mid-batch with no completion pulse.

Structure
REQ-038 State enum and phase-next helper constants SHALL live in shared package dfr_pkg.
REQ-039 Single sub-module dfr_wait_timer (load/clear, enable, limit compare, expired flag) SHALL implement REQ-031.

Verification
REQ-040 init_len=3, run_len=4, skip_mm=0, valid 2 cycles after each en -> 7 reservoir_en, 4 history_en, 1 mm_start, 1 dfr_done.
REQ-041 init_len=0, run_len=0, skip_mm=1 -> CLEAR then DONE; dfr_done 2 cycles after start, no en pulses.
REQ-042 timeout_limit=5, valid never asserted -> timeout_err=1 after 5 INIT_WAIT cycles, busy=0, no dfr_done.
REQ-043 abort during RUN_WAIT at sample 2 of 6 -> aborted=1, IDLE next cycle; new start clears aborted and reruns full batch.
REQ-044 rst asserted in MM_WAIT -> all outputs 0 next cycle; start accepted afterwards.
REQ-045 valid asserted in RUN_STEP and during DONE -> ignored; sample_idx counts only WAIT-state valids.
